rolha_stock_ctrl: RTL and testbench
===================================

ROLHA_STOCK_CTRL -- requirements
Module: rolha_stock_ctrl

Interface
REQ-001 SHALL have parameter MAX_ROLHAS, default 15: stock capacity in corks (count width 4 bits).
REQ-002 SHALL have parameter LIMIAR, default 5: minimum stock for which rolha5 is asserted.
REQ-003 SHALL have parameter DROP_CYCLES, default 4: number of cycles the drop actuator is held per cork.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 disp  input  1  dispense request level from the dispenser FSM.
REQ-008 add_rolha  input  1  add-cork level from the dispenser FSM; each rising edge adds one cork.
REQ-009 rolha5  output  1  high when count >= LIMIAR.
REQ-010 cheio  output  1  high when count == MAX_ROLHAS.
REQ-011 vazio  output  1  high when count == 0.
REQ-012 count  output  4  current stock.
REQ-013 drop  output  1  cork-release actuator.
REQ-014 erro_cheio  output  1  one-cycle pulse when an add is rejected because the stock is full.

Function
REQ-015 SHALL detect rising edges of disp and add_rolha by comparing each input with a registered copy of its previous value. An edge is valid in the cycle where the input is 1 and the registered copy is 0.
REQ-016 SHALL use a three-state FSM: IDLE, DROP, WAIT_REL.
REQ-017 In IDLE, a disp edge with count > 0 SHALL:
- decrement count at that clock edge;
- move the FSM to DROP;
- load the drop timer with DROP_CYCLES.
REQ-018 In IDLE, a disp edge with count == 0 SHALL be ignored: state, count and drop are unchanged.
REQ-019 drop SHALL equal 1 exactly while the FSM is in DROP, for exactly DROP_CYCLES consecutive cycles.
REQ-020 When the drop timer expires, the FSM SHALL move from DROP to WAIT_REL.
REQ-021 In WAIT_REL, the FSM SHALL move to IDLE in the cycle after disp is sampled 0, and SHALL remain in WAIT_REL while disp is 1.
REQ-022 disp edges seen in DROP or WAIT_REL SHALL be ignored.
REQ-023 An add_rolha edge SHALL increment count in any FSM state when count < MAX_ROLHAS.
REQ-024 An add_rolha edge at count == MAX_ROLHAS with no accepted decrement in the same cycle SHALL leave count unchanged and pulse erro_cheio for one cycle (registered).
REQ-025 For simultaneous accepted add and disp edges, count SHALL be next = count + inc - dec, with inc accepted at MAX_ROLHAS because of the concurrent dec. Count never wraps below 0 or above MAX_ROLHAS.
REQ-026 rolha5, cheio and vazio SHALL be combinational decodes of the registered count. They therefore reflect a change one cycle after the edge cycle.

Reset
REQ-027 While reset is 1 at a clock edge, the block SHALL force:
- count = 0 and FSM = IDLE;
- drop timer = 0;
- edge registers = 0;
- erro_cheio = 0.
REQ-028 After reset, outputs SHALL be rolha5=0, cheio=0, vazio=1, count=0, drop=0, erro_cheio=0.
REQ-029 Reset asserted mid-DROP SHALL abort the drop immediately (drop=0 next cycle). The cork already decremented is not restored.
REQ-030 An input held high through the deassertion of reset SHALL register as an edge on the first cycle after reset, because the edge registers cleared to 0.

Structure
REQ-031 FSM state encodings, default MAX_ROLHAS, LIMIAR and DROP_CYCLES SHALL reside in a shared package with the bottling-system constants.
REQ-032 Edge detection SHALL be a sub-module detector_borda (inputs clk, reset, sinal; output borda), instantiated twice.

Verification
REQ-033 Reset, then 6 add_rolha pulses of 2 cycles each -> count=6, rolha5=1 from the cycle after the 5th edge, vazio=0.
REQ-034 count=6, disp held high 10 cycles, then low -> count=5, drop high for exactly 4 cycles, FSM returns to IDLE one cycle after disp falls. A second disp pulse during the drop is ignored.
REQ-035 count=0, disp pulse -> drop stays 0, count stays 0, vazio stays 1.
REQ-036 16 add pulses from count=0 -> count saturates at 15, cheio=1, the 16th pulse produces a single-cycle erro_cheio.
REQ-037 count=15, add and disp rising in the same cycle -> count stays 15, drop asserted, no erro_cheio. Repeated at count=0 -> count=1, no drop.
REQ-038 Reset asserted in the 2nd drop cycle -> next cycle drop=0, count=0, FSM=IDLE.

Source files
------------

// File: rtl/rolha_stock_ctrl_pkg.sv
// Shared definitions for the cork stock controller of the bottling line:
// stock counter width, default capacity/threshold/drop timing, FSM states.
package rolha_stock_ctrl_pkg;

    // Stock counter width (covers 0..15 corks).
    localparam int CNT_W = 4;

    // Default cork capacity of the feeder magazine.
    localparam int MAX_ROLHAS_DEF = 15;

    // Default low-stock threshold driving rolha5.
    localparam int LIMIAR_DEF = 5;

    // Default number of cycles the release actuator is held per cork.
    localparam int DROP_CYCLES_DEF = 4;

    // Dispense sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DROP     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

endpackage : rolha_stock_ctrl_pkg

// File: rtl/rolha_stock_ctrl_detector_borda.sv
// Rising-edge detector: registers the previous value of sinal and flags
// the cycle where sinal is 1 while its registered copy is still 0.
module detector_borda (
    input  logic clk,
    input  logic reset,
    input  logic sinal,
    output logic borda
);

    logic sinal_q;

    // Previous-value register; cleared by reset so a level held high
    // through reset is seen as an edge on the first cycle afterwards.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block ordering.
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal;
        end
    end

    assign borda = sinal & ~sinal_q;

endmodule : detector_borda

// File: rtl/rolha_stock_ctrl.sv
// Cork stock controller: keeps the cork count, drives the release actuator
// for a fixed number of cycles per dispensed cork and flags stock status.
module rolha_stock_ctrl
    import rolha_stock_ctrl_pkg::*;
#(
    parameter int MAX_ROLHAS  = MAX_ROLHAS_DEF,
    parameter int LIMIAR      = LIMIAR_DEF,
    parameter int DROP_CYCLES = DROP_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             disp,
    input  logic             add_rolha,
    output logic             rolha5,
    output logic             cheio,
    output logic             vazio,
    output logic [CNT_W-1:0] count,
    output logic             drop,
    output logic             erro_cheio
);

    localparam int                TMR_W    = $clog2(DROP_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_ROLHAS);
    localparam logic [CNT_W-1:0] LIM_C    = CNT_W'(LIMIAR);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DROP_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);

    logic             disp_edge;
    logic             add_edge;
    logic             dec_ok;
    logic             inc_ok;
    logic             add_full;
    state_t           state;
    state_t           state_next;
    logic [TMR_W-1:0] timer;

    detector_borda u_borda_disp (
        .clk   (clk),
        .reset (reset),
        .sinal (disp),
        .borda (disp_edge)
    );

    detector_borda u_borda_add (
        .clk   (clk),
        .reset (reset),
        .sinal (add_rolha),
        .borda (add_edge)
    );

    // Accept/reject decisions for this cycle's edges; an add at full stock
    // is still accepted when a cork leaves in the same cycle.
    always_comb begin
        dec_ok   = (state == IDLE) && disp_edge && (count != '0);
        inc_ok   = add_edge && ((count < MAX_C) || dec_ok);
        add_full = add_edge && (count >= MAX_C) && !dec_ok;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:     if (dec_ok)           state_next = DROP;
            DROP:     if (timer <= TMR_LAST) state_next = WAIT_REL;
            WAIT_REL: if (!disp)            state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // FSM outputs: the actuator is driven for the whole DROP state.
    always_comb begin
        drop = (state == DROP);
    end

    // Drop timer: loaded when a cork is released, counts down in DROP.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (dec_ok) begin
            timer <= TMR_LOAD;
        end else if ((state == DROP) && (timer != '0)) begin
            timer <= timer - TMR_LAST;
        end
    end

    // Stock counter and registered full-rejection pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            erro_cheio <= 1'b0;
        end else begin
            count      <= count + CNT_W'(inc_ok) - CNT_W'(dec_ok);
            erro_cheio <= add_full;
        end
    end

    // Status decodes of the registered count.
    always_comb begin
        rolha5 = (count >= LIM_C);
        cheio  = (count == MAX_C);
        vazio  = (count == '0);
    end

endmodule : rolha_stock_ctrl

// File: tb/tb_rolha_stock_ctrl.sv
// Self-checking bench for rolha_stock_ctrl: each step pushes the expected
// post-edge outputs to a scoreboard, clocks the DUT, then pops and compares.
module tb_rolha_stock_ctrl;

    localparam int MAXR = 15;
    localparam int LIM  = 5;

    typedef struct {
        string      tag;
        int         cnt;
        logic       drp;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp;
    logic       add_rolha;
    logic       rolha5;
    logic       cheio;
    logic       vazio;
    logic [3:0] count;
    logic       drop;
    logic       erro_cheio;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    rolha_stock_ctrl #(
        .MAX_ROLHAS  (15),
        .LIMIAR      (5),
        .DROP_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .disp       (disp),
        .add_rolha  (add_rolha),
        .rolha5     (rolha5),
        .cheio      (cheio),
        .vazio      (vazio),
        .count      (count),
        .drop       (drop),
        .erro_cheio (erro_cheio)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".count"},  32'(count),      32'(e.cnt));
        check({e.tag, ".drop"},   32'(drop),       32'(e.drp));
        check({e.tag, ".erro"},   32'(erro_cheio), 32'(e.err));
        check({e.tag, ".rolha5"}, 32'(rolha5),     32'(e.cnt >= LIM));
        check({e.tag, ".cheio"},  32'(cheio),      32'(e.cnt == MAXR));
        check({e.tag, ".vazio"},  32'(vazio),      32'(e.cnt == 0));
    endtask

    // Drive inputs for one cycle, push the expected post-edge state, clock, compare.
    task automatic step(input logic d, input logic a, input int cnt,
                        input logic drp, input logic err, input string tag);
        exp_t e;
        disp      = d;
        add_rolha = a;
        e.tag = tag;
        e.cnt = cnt;
        e.drp = drp;
        e.err = err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, "rst");
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, "rst");
        reset = 1'b0;
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, "post_rst");
    endtask

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        disp      = 1'b0;
        add_rolha = 1'b0;
        do_reset();

        // Six 2-cycle add pulses.
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, i, 1'b0, 1'b0, $sformatf("A_add%0d_hi", i));
            step(1'b0, 1'b1, i, 1'b0, 1'b0, $sformatf("A_add%0d_hi2", i));
            step(1'b0, 1'b0, i, 1'b0, 1'b0, $sformatf("A_add%0d_lo", i));
        end

        // disp held 10 cycles: one cork, 4 drop cycles, then wait for release.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 5, 1'b1, 1'b0, $sformatf("B_drop%0d", i));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 5, 1'b0, 1'b0, $sformatf("B_hold%0d", i));
        step(1'b0, 1'b0, 5, 1'b0, 1'b0, "B_fall");
        // Back in IDLE one cycle after the fall: a new press is accepted.
        step(1'b1, 1'b0, 4, 1'b1, 1'b0, "B_reidle");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4, 1'b1, 1'b0, "B_drop_b");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 4, 1'b0, 1'b0, "B_end");

        // Second disp pulse inside the drop window is ignored.
        step(1'b1, 1'b0, 3, 1'b1, 1'b0, "B2_press");
        step(1'b0, 1'b0, 3, 1'b1, 1'b0, "B2_d2");
        step(1'b1, 1'b0, 3, 1'b1, 1'b0, "B2_ignored");
        step(1'b0, 1'b0, 3, 1'b1, 1'b0, "B2_d4");
        step(1'b0, 1'b0, 3, 1'b0, 1'b0, "B2_wait");
        step(1'b0, 1'b0, 3, 1'b0, 1'b0, "B2_idle");

        // Dispense on empty stock does nothing.
        do_reset();
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, "C_empty_press");
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, "C_empty_hold");
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, "C_empty_rel");

        // 16 adds: saturate at 15, 16th gives a one-cycle erro_cheio.
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, (i > MAXR) ? MAXR : i, 1'b0, (i == 16), $sformatf("D_add%0d", i));
            step(1'b0, 1'b0, (i > MAXR) ? MAXR : i, 1'b0, 1'b0, $sformatf("D_lo%0d", i));
        end

        // Simultaneous add and disp at full stock.
        step(1'b1, 1'b1, 15, 1'b1, 1'b0, "E_both_full");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 15, 1'b1, 1'b0, "E_full_drop");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 15, 1'b0, 1'b0, "E_full_end");

        // Simultaneous add and disp at empty stock: add only, FSM stays IDLE.
        do_reset();
        step(1'b1, 1'b1, 1, 1'b0, 1'b0, "E_both_empty");
        step(1'b0, 1'b0, 1, 1'b0, 1'b0, "E_empty_lo");
        step(1'b1, 1'b0, 0, 1'b1, 1'b0, "E_idle_chk");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0, "E_idle_drop");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0, "E_idle_end");

        // Reset in the 2nd drop cycle; add held high through reset release.
        do_reset();
        step(1'b0, 1'b1, 1, 1'b0, 1'b0, "F_add1");
        step(1'b0, 1'b0, 1, 1'b0, 1'b0, "F_lo1");
        step(1'b0, 1'b1, 2, 1'b0, 1'b0, "F_add2");
        step(1'b0, 1'b0, 2, 1'b0, 1'b0, "F_lo2");
        step(1'b1, 1'b0, 1, 1'b1, 1'b0, "F_drop1");
        step(1'b0, 1'b0, 1, 1'b1, 1'b0, "F_drop2");
        reset = 1'b1;
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, "F_abort");
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, "F_rst_hold");
        reset = 1'b0;
        step(1'b0, 1'b1, 1, 1'b0, 1'b0, "F_edge_after_rst");
        step(1'b0, 1'b0, 1, 1'b0, 1'b0, "F_final");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rolha_stock_ctrl
